// File: rtl/rv32i_types.sv
// Shared load-path types for the load alignment unit.
//   load_funct3_t : RISC-V load funct3 encodings
//   lau_state_t   : load alignment unit FSM states
//   load_size()   : access size in bytes (1/2/4/8) from funct3
package rv32i_types;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    RESP = 2'd3
  } lau_state_t;

  // The low two funct3 bits encode log2 of the access size.
  function automatic logic [3:0] load_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    return 4'd1;
      2'd1:    return 4'd2;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// Bus bundle for load_align_unit: request, cache port and response.
//   slave  : the load alignment unit side
//   master : the datapath / cache / consumer side
// Handshakes: a request transfers on the rising edge where req_valid and
// req_ready are both high; a response transfers where rsp_valid and rsp_ready
// are both high, and rsp_data/rsp_err hold steady while rsp_valid waits.
// The cache side is strobe based: mem_read is held with a constant
// mem_address until the single-cycle mem_resp returns mem_rdata.
// dbg_state mirrors the FSM state for observation.
interface load_align_unit_if
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic [2:0]        req_funct3;
  logic              mem_read;
  logic [XLEN-1:0]   mem_address;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_resp;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_data;
  logic              rsp_err;
  lau_state_t        dbg_state;

  modport slave (
    input  req_valid, req_addr, req_funct3, mem_rdata, mem_resp, rsp_ready,
    output req_ready, mem_read, mem_address, rsp_valid, rsp_data, rsp_err,
           dbg_state
  );

  modport master (
    output req_valid, req_addr, req_funct3, mem_rdata, mem_resp, rsp_ready,
    input  req_ready, mem_read, mem_address, rsp_valid, rsp_data, rsp_err,
           dbg_state
  );
endinterface

// File: rtl/load_extract.sv
// Combinational load extractor.
//   beat_pair : {second beat, first beat}, little-endian bytes
//   offset    : byte offset of the access within the first beat
//   funct3    : load type (size and signedness)
//   ext_data  : selected bytes, sign- or zero-extended to XLEN
module load_extract
  import rv32i_types::*;
#(
  parameter  int XLEN   = 32,
  localparam int WBYTES = XLEN / 8,
  localparam int OFFW   = $clog2(WBYTES)
) (
  input  logic [2*XLEN-1:0] beat_pair,
  input  logic [OFFW-1:0]   offset,
  input  logic [2:0]        funct3,
  output logic [XLEN-1:0]   ext_data
);

  logic [XLEN-1:0] low;
  logic [XLEN-1:0] mask;
  logic [3:0]      size;
  logic            sign_bit;

  always_comb begin
    low  = XLEN'(beat_pair >> {offset, 3'b000});
    size = load_size(funct3);
    mask = '0;
    for (int i = 0; i < WBYTES; i++) begin
      if (i < int'(size)) mask[i*8 +: 8] = 8'hFF;
    end
    case (funct3[1:0])
      2'd0:    sign_bit = low[7];
      2'd1:    sign_bit = low[15];
      2'd2:    sign_bit = low[31];
      default: sign_bit = low[XLEN-1];
    endcase
    ext_data = low & mask;
    // funct3[2] clear means a signed load; for full-width loads ~mask is 0.
    if (!funct3[2] && sign_bit) ext_data = ext_data | ~mask;
  end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit: accepts a byte-addressed load, issues one or two
// word-aligned cache reads, extracts and extends the addressed bytes and
// returns them over a valid/ready response.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : load_align_unit_if.slave (request, cache port, response,
//                dbg_state)
// Build option: LAU_MISALIGN_SPLIT_EN -- when defined, accesses that cross a
// word boundary are served with two cache reads; when undefined, any access
// not naturally aligned returns rsp_err without touching the cache.
module load_align_unit
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               rst_n,
  load_align_unit_if.slave  bus
);

  localparam int WBYTES = XLEN / 8;
  localparam int OFFW   = $clog2(WBYTES);

  lau_state_t             state_q, state_d;
  logic [XLEN-OFFW-1:0]   base_q, base_d;       // word index of first beat
  logic [OFFW-1:0]        off_q, off_d;
  logic [2:0]             f3_q, f3_d;
  logic [XLEN-1:0]        buf0_q, buf0_d;
`ifdef LAU_MISALIGN_SPLIT_EN
  logic [XLEN-1:0]        buf1_q, buf1_d;
`endif
  logic [XLEN-1:0]        rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;

  logic                   req_ready, mem_read, rsp_valid;
  logic [XLEN-1:0]        mem_address;
  logic                   req_illegal;
  logic                   req_reject;
  logic [2*XLEN-1:0]      beat_pair;
  logic [XLEN-1:0]        ext_data;

  // Request decode straight from the bus, used only on the accept cycle.
  always_comb begin
    req_illegal = (bus.req_funct3 == 3'b111) ||
                  ((XLEN == 32) && ((bus.req_funct3 == 3'b011) ||
                                    (bus.req_funct3 == 3'b110)));
`ifdef LAU_MISALIGN_SPLIT_EN
    req_reject = req_illegal;
`else
    req_reject = req_illegal ||
                 (|(bus.req_addr[OFFW-1:0] &
                    OFFW'(load_size(bus.req_funct3) - 4'd1)));
`endif
  end

  // Extraction works on the beat arriving this cycle so the result can be
  // registered on the same edge that completes the last read.
  always_comb begin
`ifdef LAU_MISALIGN_SPLIT_EN
    if (state_q == RD1) beat_pair = {bus.mem_rdata, buf0_q};
    else                beat_pair = {{XLEN{1'b0}}, bus.mem_rdata};
`else
    beat_pair = {{XLEN{1'b0}}, bus.mem_rdata};
`endif
  end

  load_extract #(.XLEN(XLEN)) u_extract (
    .beat_pair (beat_pair),
    .offset    (off_q),
    .funct3    (f3_q),
    .ext_data  (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    off_d      = off_q;
    f3_d       = f3_q;
    buf0_d     = buf0_q;
`ifdef LAU_MISALIGN_SPLIT_EN
    buf1_d     = buf1_q;
`endif
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready   = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    rsp_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          base_d     = bus.req_addr[XLEN-1:OFFW];
          off_d      = bus.req_addr[OFFW-1:0];
          f3_d       = bus.req_funct3;
          buf0_d     = '0;
`ifdef LAU_MISALIGN_SPLIT_EN
          buf1_d     = '0;
`endif
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          if (req_reject) begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end else begin
            state_d   = RD0;
          end
        end
      end
      RD0: begin
        mem_read    = 1'b1;
        mem_address = {base_q, {OFFW{1'b0}}};
        if (bus.mem_resp) begin
          buf0_d = bus.mem_rdata;
`ifdef LAU_MISALIGN_SPLIT_EN
          if ((int'(off_q) + int'(load_size(f3_q))) > WBYTES) begin
            state_d = RD1;
          end else begin
            rsp_data_d = ext_data;
            state_d    = RESP;
          end
`else
          rsp_data_d = ext_data;
          state_d    = RESP;
`endif
        end
      end
`ifdef LAU_MISALIGN_SPLIT_EN
      RD1: begin
        mem_read    = 1'b1;
        // Next word; the increment wraps at the top of the address space.
        mem_address = {base_q + 1'b1, {OFFW{1'b0}}};
        if (bus.mem_resp) begin
          buf1_d     = bus.mem_rdata;
          rsp_data_d = ext_data;
          state_d    = RESP;
        end
      end
`endif
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      off_q      <= '0;
      f3_q       <= '0;
      buf0_q     <= '0;
`ifdef LAU_MISALIGN_SPLIT_EN
      buf1_q     <= '0;
`endif
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      off_q      <= off_d;
      f3_q       <= f3_d;
      buf0_q     <= buf0_d;
`ifdef LAU_MISALIGN_SPLIT_EN
      buf1_q     <= buf1_d;
`endif
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.mem_read    = mem_read;
  assign bus.mem_address = mem_address;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.dbg_state   = state_q;

endmodule
